xilinx_fifo_rd_stream: RTL and testbench

Read-side adapter for the team's Xilinx FIFO wrappers. It drives the FIFO's `rd_en`, absorbs the one-cycle standard-mode read latency, and presents the FIFO contents as a valid/ready stream with optional fixed-length `m_tlast` framing. It sits in the FIFO's read clock domain between the FIFO `dout`/`empty`/`rd_en` pins and a downstream stream consumer. Using it, FIFO output runs at full throughput under arbitrary back-pressure and never over-reads.

---
 rtl/xilinx_fifo_rd_stream.sv | 81 ++++++++
 tb/tb_xilinx_fifo_rd_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xilinx_fifo_rd_stream.sv
// rtl/xilinx_fifo_rd_stream.sv - FIFO read-side adapter to valid/ready stream
// Absorbs the one-cycle standard-mode FIFO read latency with a 3-entry skid buffer.
module xilinx_fifo_rd_stream #(
  parameter int DSIZE  = 18,
  parameter int LENGTH = 0
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [DSIZE-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [1:0]       buf_count
);

  logic [DSIZE-1:0] r_mem [0:2];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_cnt;
  logic             r_inflight;
  logic             w_pop;
  logic [2:0]       w_credit_used;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts the word already requested, so the buffer can never overflow
  // and the read strobe never depends on the downstream ready.
  assign w_credit_used = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign fifo_rd_en    = !rd_rst && !fifo_empty && (w_credit_used < 3'd3);

  assign m_tvalid  = (r_cnt != 2'd0);
  assign m_tdata   = r_mem[r_rd_ptr];
  assign w_pop     = m_tvalid && m_tready;
  assign buf_count = r_cnt;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (r_inflight) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)      r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst && r_inflight) r_mem[r_wr_ptr] <= fifo_dout;
  end

  generate
    if (LENGTH > 0) begin : g_frame
      localparam int BW = $clog2(LENGTH + 1);
      logic [BW-1:0] r_beat;

      assign m_tlast = m_tvalid && (r_beat == BW'(LENGTH - 1));

      always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
          r_beat <= '0;
        end else if (w_pop) begin
          r_beat <= m_tlast ? '0 : r_beat + BW'(1);
        end
      end
    end else begin : g_noframe
      assign m_tlast = 1'b0;
    end
  endgenerate

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(r_inflight && (r_cnt == 2'd3) && !w_pop));

endmodule

// File: tb/tb_xilinx_fifo_rd_stream.sv
// tb/tb_xilinx_fifo_rd_stream.sv - scoreboard bench for xilinx_fifo_rd_stream
// FIFO behavioural model feeds the DUT; a negedge monitor checks beats against the queue.
module tb_xilinx_fifo_rd_stream;
  localparam int DSIZE  = 18;
  localparam int LENGTH = 4;

  logic             rd_clk = 1'b0;
  logic             rd_rst;
  logic [DSIZE-1:0] fifo_dout = '0;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [DSIZE-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [1:0]       buf_count;

  always #5 rd_clk = ~rd_clk;

  xilinx_fifo_rd_stream #(.DSIZE(DSIZE), .LENGTH(LENGTH)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .buf_count  (buf_count)
  );

  logic [DSIZE-1:0] fifo_q [$];
  logic [DSIZE-1:0] exp_q  [$];
  int               fifo_n = 0;
  logic             gate_empty;
  int               n_vec = 0;
  int               n_err = 0;
  int               beat_m = 0;
  int               tl_seen = 0;
  logic             prev_stall = 1'b0;
  logic [DSIZE-1:0] prev_data = '0;

  assign fifo_empty = gate_empty || (fifo_n == 0);

  // Standard-mode FIFO: data appears the cycle after the read strobe.
  always @(posedge rd_clk) begin
    if (rd_rst) begin
      fifo_q.delete();
      fifo_n <= 0;
    end else if (fifo_rd_en) begin
      fifo_dout <= fifo_q.pop_front();
      fifo_n    <= fifo_n - 1;
    end
  end

  always @(posedge rd_clk) begin
    if (rd_rst) begin
      exp_q.delete();
      beat_m     = 0;
      prev_stall = 1'b0;
    end
  end

  always @(negedge rd_clk) begin
    logic [DSIZE-1:0] e;
    logic             el;
    if (!rd_rst) begin
      if (prev_stall) begin
        n_vec++;
        if (!m_tvalid || m_tdata !== prev_data) begin
          n_err++;
          $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h",
                   m_tvalid, m_tdata, prev_data);
        end
      end
      if (m_tvalid && m_tready) begin
        n_vec++;
        if (m_tlast) tl_seen++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: data=%h required no beat", m_tdata);
        end else begin
          e  = exp_q.pop_front();
          el = (beat_m == LENGTH - 1);
          if (m_tdata !== e || m_tlast !== el) begin
            n_err++;
            $display("FAIL beat: data=%h last=%0b required data=%h last=%0b",
                     m_tdata, m_tlast, e, el);
          end
          beat_m = (beat_m + 1) % LENGTH;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic load(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_n = fifo_n + 1;
  endtask

  task automatic drain(input int maxc, input string nm);
    m_tready   = 1'b1;
    gate_empty = 1'b0;
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) step();
    repeat (3) step();
    check(nm, exp_q.size(), 0);
  endtask

  initial begin
    logic [11:0] rd_hist;
    logic [11:0] v_hist;
    logic [1:0]  bc5;
    int          rd_pulses;
    int          tl_base;
    logic        got;

    rd_rst = 1'b1; gate_empty = 1'b0; m_tready = 1'b0;
    step(); step();
    @(negedge rd_clk);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_buf_count", buf_count, 0);
    step();
    rd_rst = 1'b0; m_tready = 1'b1;

    // single word
    step();
    load(18'h00AA5);
    for (int i = 0; i < 12; i++) begin
      @(negedge rd_clk);
      rd_hist[i] = fifo_rd_en;
      v_hist[i]  = m_tvalid;
    end
    check("single_rd_en", rd_hist, 12'h001);
    check("single_tvalid", v_hist, 12'h004);

    // 8-word burst at full rate
    step();
    for (int i = 1; i <= 8; i++) load(DSIZE'(i));
    bc5 = 2'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge rd_clk);
      rd_hist[i] = fifo_rd_en;
      v_hist[i]  = m_tvalid;
      if (i == 5) bc5 = buf_count;
    end
    check("burst_rd_en", rd_hist, 12'h0FF);
    check("burst_tvalid", v_hist, 12'h3FC);
    check("burst_buf_count", bc5, 1);

    // full stall then release
    step();
    m_tready = 1'b0;
    for (int i = 1; i <= 10; i++) load(DSIZE'(12'h100 + i));
    rd_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge rd_clk);
      if (fifo_rd_en) rd_pulses++;
    end
    check("stall_reads", rd_pulses, 3);
    check("stall_buf_count", buf_count, 3);
    check("stall_tdata", m_tdata, 18'h101);
    step();
    m_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge rd_clk);
      v_hist[i] = m_tvalid;
    end
    check("release_tvalid", v_hist, 12'h3FF);

    // framing with random back-pressure, counter aligned by a reset
    step(); rd_rst = 1'b1;
    step(); rd_rst = 1'b0;
    tl_base = tl_seen;
    for (int i = 0; i < 10; i++) load(DSIZE'(18'h2000 + i));
    for (int i = 0; i < 40; i++) begin
      step();
      m_tready = ($urandom_range(1, 0) == 1);
    end
    drain(60, "frame_drain");
    check("frame_tlast_10", tl_seen - tl_base, 2);
    step();
    load(18'h3001); load(18'h3002);
    drain(20, "tail_drain");
    check("frame_tlast_12", tl_seen - tl_base, 3);

    // reset mid-burst with 2 buffered and 1 in flight
    step();
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) load(DSIZE'(18'h4000 + i));
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge rd_clk);
      if (buf_count == 2'd2) got = 1'b1;
    end
    check("rst_setup", got, 1);
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    @(negedge rd_clk);
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_buf_count", buf_count, 0);
    check("midrst_tlast", m_tlast, 0);
    step();
    tl_base = tl_seen;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) load(DSIZE'(18'h5000 + i));
    drain(30, "midrst_drain");
    check("midrst_tlast_cnt", tl_seen - tl_base, 1);

    // random empty/ready toggling
    for (int c = 0; c < 10000; c++) begin
      step();
      gate_empty = ($urandom_range(3, 0) == 0);
      m_tready   = ($urandom_range(2, 0) != 0);
      if ($urandom_range(1, 0) == 1 && fifo_n < 16) load(DSIZE'($urandom));
    end
    drain(200, "random_drain");
    @(negedge rd_clk);
    check("final_tvalid", m_tvalid, 0);
    check("final_fifo_n", fifo_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
